// File: rtl/rv_multicycle_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle sequencer and memory.
// The sequencer owns the request side; memory returns a one-cycle ack pulse.
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core,
// with memory timeout detection, sticky fault code and retired-instruction count.
module rv_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               br_cond,
  rv_multicycle_ctrl_if.master bus,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_sel,
  output logic               alu_src_b,
  output logic               rf_we,
  output logic [1:0]         wb_sel,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_R,
    OP_I,
    OP_LD,
    OP_ST,
    OP_BR,
    OP_JAL,
    OP_JALR,
    OP_LUI
  } op_t;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST   = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_LUI  = 7'b0110111;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;

  // Last wait cycle index: no ack on this cycle means TIMEOUT request cycles elapsed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           st;
  op_t              op;
  logic [7:0]       tcnt;
  logic [1:0]       flt;
  logic [CNT_W-1:0] ret_cnt;

  logic             legal;
  op_t              dec_op;
  logic             retire;

  always_comb begin
    legal  = 1'b1;
    dec_op = OP_R;
    case (opcode)
      OPC_R:    dec_op = OP_R;
      OPC_I:    dec_op = OP_I;
      OPC_LD:   dec_op = OP_LD;
      OPC_ST:   dec_op = OP_ST;
      OPC_BR:   dec_op = OP_BR;
      OPC_JAL:  dec_op = OP_JAL;
      OPC_JALR: dec_op = OP_JALR;
      OPC_LUI:  dec_op = OP_LUI;
      default:  legal  = 1'b0;
    endcase
  end

  assign retire = ((st == S_EXEC) && (op == OP_BR)) ||
                  ((st == S_MEM) && (op == OP_ST) && bus.mem_ack) ||
                  (st == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      op      <= OP_R;
      tcnt    <= '0;
      flt     <= FLT_NONE;
      ret_cnt <= '0;
    end else begin
      tcnt <= '0;
      if (retire) begin
        ret_cnt <= ret_cnt + 1'b1;
      end
      case (st)
        S_IDLE: begin
          if (run) begin
            st <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            st <= S_DECODE;
          end else if (tcnt == TO_LAST) begin
            flt <= FLT_TIMEOUT;
            st  <= S_HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DECODE: begin
          if (legal) begin
            op <= dec_op;
            st <= S_EXEC;
          end else begin
            flt <= FLT_ILLEGAL;
            st  <= S_HALT;
          end
        end
        S_EXEC: begin
          case (op)
            OP_BR:          st <= run ? S_FETCH : S_IDLE;
            OP_LD, OP_ST:   st <= S_MEM;
            default:        st <= S_WB;
          endcase
        end
        S_MEM: begin
          // An ack on the final wait cycle takes priority over the timeout.
          if (bus.mem_ack) begin
            if (op == OP_LD) begin
              st <= S_WB;
            end else begin
              st <= run ? S_FETCH : S_IDLE;
            end
          end else if (tcnt == TO_LAST) begin
            flt <= FLT_TIMEOUT;
            st  <= S_HALT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WB: begin
          st <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: begin
          st <= S_HALT;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    alu_src_b    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    case (st)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        ir_we       = bus.mem_ack;
      end
      S_EXEC: begin
        alu_src_b = (op == OP_I) || (op == OP_LUI) || (op == OP_LD) || (op == OP_ST);
        if (op == OP_BR) begin
          pc_we  = 1'b1;
          pc_sel = br_cond ? 2'b01 : 2'b00;
        end
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = (op == OP_ST);
        pc_we        = (op == OP_ST) && bus.mem_ack;
      end
      S_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (op)
          OP_LD: begin
            wb_sel = 2'b01;
          end
          OP_JAL: begin
            wb_sel = 2'b10;
            pc_sel = 2'b01;
          end
          OP_JALR: begin
            wb_sel = 2'b10;
            pc_sel = 2'b10;
          end
          default: begin
            wb_sel = 2'b00;
          end
        endcase
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
  end

  assign state   = st;
  assign retired = ret_cnt;
  assign fault   = flt;

endmodule
